// File: rtl/spi_reg_master.sv
// -----------------------------------------------------------------------------
// spi_reg_master
//
// SPI initiator for the 2-byte register frame of the SPI register slave.
// One host request (rw, addr, wdata) becomes one 16-bit transfer:
//   MOSI byte 0 = {rw, zero padding, addr}, byte 1 = wdata (write) or 8'h00.
//   MISO byte 0 -> status, byte 1 -> rdata.
// Frame timing, in ena-qualified clk cycles:
//   SETUP CLK_DIV, SHIFT 32*CLK_DIV, HOLD CLK_DIV, GAP CLK_DIV.
// When the frame ends, done is registered 34*CLK_DIV cycles after the
// accepting edge.
//
// Ports
//   clk       system clock
//   rstb      asynchronous active-low reset
//   ena       clock enable; low freezes every register
//   mode      {CPOL,CPHA}, latched at accept
//   start     request, accepted only in IDLE
//   rw        1 = write, 0 = read (latched at accept)
//   addr      register address (latched at accept)
//   wdata     write data (latched at accept)
//   busy      high from the cycle after accept until back in IDLE
//   done      one-cycle pulse at end of frame; rdata/status valid
//   rdata     second MISO byte
//   status    first MISO byte
//   spi_clk   serial clock
//   spi_mosi  serial data out, MSB first
//   spi_miso  serial data in, MSB first
//   spi_cs_n  chip select, active low
// -----------------------------------------------------------------------------
module spi_reg_master #(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic [7:0]        status,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg;
    logic [5:0]         edge_reg;      // completed spi_clk toggles, 0..32
    logic [4:0]         bit_reg;       // MISO samples taken, 0..16
    logic               cpha_reg;
    logic [15:0]        tx_sr_reg;
    logic [15:0]        rx_sr_reg;
    logic               sclk_reg;
    logic               mosi_reg;
    logic               cs_n_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [REG_W-1:0]   rdata_reg;
    logic [7:0]         status_reg;

    // Address zero-extended to the 7 low bits of byte 0; works for ADDR_W=7
    // where there is no padding at all.
    logic [6:0]  addr_ext;
    logic [15:0] frame_word;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_addr_ext
            if (gi < ADDR_W) begin : g_bit
                assign addr_ext[gi] = addr[gi];
            end else begin : g_zero
                assign addr_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign frame_word = {rw, addr_ext, (rw ? wdata[7:0] : 8'h00)};

    logic div_last;
    logic edge_last;
    logic lead_edge;
    logic toggle;
    logic sample_now;
    logic shift_now;

    assign div_last  = (div_reg == DIV_W'(CLK_DIV - 1));
    assign edge_last = (edge_reg == 6'd31);
    // The next toggle is a leading edge when an even number have happened.
    assign lead_edge = ~edge_reg[0];

    always_comb begin
        state_next = state_reg;
        toggle     = 1'b0;
        sample_now = 1'b0;
        shift_now  = 1'b0;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: if (div_last) state_next = ST_SHIFT;
            ST_SHIFT: begin
                toggle = div_last;
                // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
                sample_now = div_last && (lead_edge ^ cpha_reg) && (bit_reg != 5'd16);
                // The other edge moves MOSI; with CPHA=0 the final trailing
                // edge leaves MOSI alone.
                shift_now  = div_last && !(lead_edge ^ cpha_reg) && !(!cpha_reg && edge_last);
                if (div_last && edge_last) state_next = ST_HOLD;
            end
            ST_HOLD:  if (div_last) state_next = ST_GAP;
            ST_GAP:   if (div_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg  <= ST_IDLE;
            div_reg    <= '0;
            edge_reg   <= '0;
            bit_reg    <= '0;
            cpha_reg   <= 1'b0;
            tx_sr_reg  <= '0;
            rx_sr_reg  <= '0;
            sclk_reg   <= 1'b0;
            mosi_reg   <= 1'b0;
            cs_n_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            rdata_reg  <= '0;
            status_reg <= '0;
        end else if (ena) begin
            state_reg <= state_next;
            done_reg  <= 1'b0;

            if (state_reg == ST_IDLE || div_last) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    sclk_reg <= mode[1];
                    if (start) begin
                        cpha_reg  <= mode[0];
                        busy_reg  <= 1'b1;
                        cs_n_reg  <= 1'b0;
                        edge_reg  <= '0;
                        bit_reg   <= '0;
                        rx_sr_reg <= '0;
                        // CPHA=0 presents bit 15 during SETUP, so the shift
                        // register starts one bit ahead; CPHA=1 drives bit 15
                        // on the first leading edge.
                        if (mode[0]) begin
                            tx_sr_reg <= frame_word;
                            mosi_reg  <= 1'b0;
                        end else begin
                            tx_sr_reg <= {frame_word[14:0], 1'b0};
                            mosi_reg  <= frame_word[15];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (toggle) begin
                        sclk_reg <= ~sclk_reg;
                        edge_reg <= edge_reg + 6'd1;
                    end
                    if (sample_now) begin
                        rx_sr_reg <= {rx_sr_reg[14:0], spi_miso};
                        bit_reg   <= bit_reg + 5'd1;
                    end
                    if (shift_now) begin
                        mosi_reg  <= tx_sr_reg[15];
                        tx_sr_reg <= {tx_sr_reg[14:0], 1'b0};
                    end
                end
                ST_HOLD: begin
                    if (div_last) begin
                        cs_n_reg   <= 1'b1;
                        done_reg   <= 1'b1;
                        status_reg <= rx_sr_reg[15:8];
                        rdata_reg  <= rx_sr_reg[7:0];
                    end
                end
                ST_GAP: begin
                    if (div_last) busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign status   = status_reg;
    assign spi_clk  = sclk_reg;
    assign spi_mosi = mosi_reg;
    assign spi_cs_n = cs_n_reg;

endmodule
